// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipeline_seq_pkg;

  localparam int PC_W_DEF  = 21;
  localparam int REG_W_DEF = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2,
    FAULT    = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and a freeze input.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_freeze,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !i_freeze && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush arbitration for the 5-stage pipeline with memory-wait timeout
// and saturating debug counters.
//
// state    | meaning
// RUN      | normal issue; hazards resolved each cycle
// MEM_WAIT | data memory stalled last cycle; IF..MEM frozen
// HALTED   | halt retired; pipeline frozen until rst
// FAULT    | memory wait timed out; pipeline frozen until rst
module pipeline_sequencer
  import pipeline_seq_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int MEM_TIMEOUT = 16,
  parameter int ZERO_REG    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             pc_sel,
  output logic [PC_W-1:0]  pc_target,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       state_o,
  output logic             mem_timeout_err,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_events
);

  // Wide enough to reach MEM_TIMEOUT-1; wraps harmlessly when timeout is disabled.
  localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  seq_state_t      r_state;
  seq_state_t      w_next;
  logic [WC_W-1:0] r_wait_cnt;
  logic [WC_W-1:0] w_wait_next;
  logic            r_err;

  logic            w_mem_stall;
  logic            w_load_use;
  logic            w_redirect;
  logic            w_timeout;
  logic            w_zero_blk;
  logic            w_stall_inc;
  logic            w_flush_inc;
  logic            w_err_set;
  logic            w_frozen;
  logic            w_pc_en;
  logic            w_pc_sel;
  stage_ctrl_t     w_if_id;
  stage_ctrl_t     w_id_ex;
  stage_ctrl_t     w_ex_mem;
  stage_ctrl_t     w_mem_wb;

  assign w_mem_stall = mem_req && !mem_ready;
  assign w_zero_blk  = (ZERO_REG != 0) && (ex_rd == '0);
  assign w_load_use  = ex_mem_read && !w_zero_blk &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));
  assign w_redirect  = ex_branch && ex_taken;
  assign w_timeout   = (MEM_TIMEOUT != 0) && w_mem_stall &&
                       (r_wait_cnt == WC_W'(MEM_TIMEOUT - 1));
  assign w_frozen    = (r_state == HALTED) || (r_state == FAULT);

  always_comb begin
    w_next      = r_state;
    w_wait_next = r_wait_cnt;
    w_pc_en     = 1'b0;
    w_pc_sel    = 1'b0;
    w_if_id     = '0;
    w_id_ex     = '0;
    w_ex_mem    = '0;
    w_mem_wb    = '0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    w_err_set   = 1'b0;

    if (rst) begin
      w_if_id.flush  = 1'b1;
      w_id_ex.flush  = 1'b1;
      w_ex_mem.flush = 1'b1;
      w_mem_wb.flush = 1'b1;
    end else begin
      case (r_state)
        RUN, MEM_WAIT: begin
          if (halt_wb) begin
            w_next = HALTED;
          end else if (w_mem_stall) begin
            // EX is frozen here, so any pending redirect is re-presented later.
            w_mem_wb.en    = 1'b1;
            w_mem_wb.flush = 1'b1;
            w_stall_inc    = 1'b1;
            w_wait_next    = r_wait_cnt + WC_W'(1);
            if (w_timeout) begin
              w_next    = FAULT;
              w_err_set = 1'b1;
            end else begin
              w_next = MEM_WAIT;
            end
          end else begin
            w_next      = RUN;
            w_wait_next = '0;
            w_pc_en     = 1'b1;
            w_if_id.en  = 1'b1;
            w_id_ex.en  = 1'b1;
            w_ex_mem.en = 1'b1;
            w_mem_wb.en = 1'b1;
            if (w_redirect) begin
              w_pc_sel      = 1'b1;
              w_if_id.flush = 1'b1;
              w_id_ex.flush = 1'b1;
              w_flush_inc   = 1'b1;
            end else if (w_load_use) begin
              w_pc_en       = 1'b0;
              w_if_id.en    = 1'b0;
              w_id_ex.flush = 1'b1;
              w_stall_inc   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  sat_counter #(.W(16)) u_stall_cnt (
    .clk      (clk),
    .i_clr    (rst),
    .i_inc    (w_stall_inc),
    .i_freeze (w_frozen),
    .o_count  (stall_cycles)
  );

  sat_counter #(.W(16)) u_flush_cnt (
    .clk      (clk),
    .i_clr    (rst),
    .i_inc    (w_flush_inc),
    .i_freeze (w_frozen),
    .o_count  (flush_events)
  );

  assign pc_en           = w_pc_en;
  assign pc_sel          = w_pc_sel;
  assign pc_target       = w_pc_sel ? ex_target : '0;
  assign if_id_en        = w_if_id.en;
  assign id_ex_en        = w_id_ex.en;
  assign ex_mem_en       = w_ex_mem.en;
  assign mem_wb_en       = w_mem_wb.en;
  assign if_id_flush     = w_if_id.flush;
  assign id_ex_flush     = w_id_ex.flush;
  assign ex_mem_flush    = w_ex_mem.flush;
  assign mem_wb_flush    = w_mem_wb.flush;
  assign state_o         = r_state;
  assign mem_timeout_err = r_err;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench: vector table, directed multi-cycle sequences and
// randomized traffic against a behavioural model of the sequencer.
module tb_pipeline_sequencer;

  localparam int PCW = 21;
  localparam int RW  = 4;
  localparam int TMO = 4;
  localparam int ZR  = 1;

  logic           clk;
  logic           rst;
  logic [RW-1:0]  id_rs1, id_rs2, ex_rd;
  logic           id_use_rs1, id_use_rs2, ex_mem_read, ex_branch, ex_taken;
  logic [PCW-1:0] ex_target;
  logic           mem_req, mem_ready, halt_wb;
  logic           pc_en, pc_sel;
  logic [PCW-1:0] pc_target;
  logic           if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0]     state_o;
  logic           mem_timeout_err;
  logic [15:0]    stall_cycles, flush_events;

  pipeline_sequencer #(
    .PC_W(PCW), .REG_W(RW), .MEM_TIMEOUT(TMO), .ZERO_REG(ZR)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch(ex_branch), .ex_taken(ex_taken),
    .ex_target(ex_target), .mem_req(mem_req), .mem_ready(mem_ready), .halt_wb(halt_wb),
    .pc_en(pc_en), .pc_sel(pc_sel), .pc_target(pc_target),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .state_o(state_o), .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: 0 run, 1 mem wait, 2 halted, 3 fault
  int m_state, m_wait, m_stall, m_flush;
  bit m_err;

  // {pc_en,pc_sel,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,if_id_fl,id_ex_fl,ex_mem_fl,mem_wb_fl}
  localparam logic [9:0] C_RUN   = 10'b1_0_1111_0000;
  localparam logic [9:0] C_LU    = 10'b0_0_0111_0100;
  localparam logic [9:0] C_BR    = 10'b1_1_1111_1100;
  localparam logic [9:0] C_MEM   = 10'b0_0_0001_0001;
  localparam logic [9:0] C_FROZE = 10'b0_0_0000_0000;
  localparam logic [9:0] C_RST   = 10'b0_0_0000_1111;

  function automatic logic [9:0] dut_ctrl();
    return {pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = '0;
    ex_mem_read = 0; ex_branch = 0; ex_taken = 0; ex_target = '0;
    mem_req = 0; mem_ready = 0; halt_wb = 0;
  endtask

  // Applies the current inputs for one clock, checking outputs against the model.
  task automatic step();
    logic [9:0]     e_ctrl;
    logic [PCW-1:0] e_tgt;
    int  n_state, n_wait, n_stall, n_flush;
    bit  n_err, ms, lu, rd;
    ms = mem_req && !mem_ready;
    lu = ex_mem_read && !(ZR != 0 && ex_rd == 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    rd = ex_branch && ex_taken;
    n_state = m_state; n_wait = m_wait; n_err = m_err;
    n_stall = m_stall; n_flush = m_flush; e_tgt = '0;
    if (rst) begin
      e_ctrl = C_RST; n_state = 0; n_wait = 0; n_err = 0; n_stall = 0; n_flush = 0;
    end else if (m_state >= 2) begin
      e_ctrl = C_FROZE;
    end else if (halt_wb) begin
      e_ctrl = C_FROZE; n_state = 2;
    end else if (ms) begin
      e_ctrl  = C_MEM;
      n_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      n_wait  = m_wait + 1;
      if (TMO != 0 && m_wait == TMO - 1) begin
        n_state = 3; n_err = 1;
      end else begin
        n_state = 1;
      end
    end else begin
      n_state = 0; n_wait = 0;
      if (rd) begin
        e_ctrl = C_BR; e_tgt = ex_target;
        n_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
      end else if (lu) begin
        e_ctrl  = C_LU;
        n_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      end else begin
        e_ctrl = C_RUN;
      end
    end
    #2;
    chk("ctrl", 32'(dut_ctrl()), 32'(e_ctrl));
    chk("pc_target", 32'(pc_target), 32'(e_tgt));
    @(posedge clk);
    #1;
    m_state = n_state; m_wait = n_wait; m_err = n_err;
    m_stall = n_stall; m_flush = n_flush;
    chk("state_o", 32'(state_o), 32'(m_state));
    chk("timeout_err", 32'(mem_timeout_err), 32'(m_err));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    chk("flush_events", 32'(flush_events), 32'(m_flush));
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  typedef struct {
    logic           mr;
    logic [RW-1:0]  rd, rs1, rs2;
    logic           u1, u2, br, tk;
    logic [PCW-1:0] tgt;
    logic           mreq, mrdy;
    logic [9:0]     ectrl;
    logic [PCW-1:0] etgt;
    logic [1:0]     est;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 21'h0,     0, 0, C_RUN, 21'h0,     2'd0};
    tbl[1]  = '{1, 3, 3, 0, 1, 0, 0, 0, 21'h0,     0, 0, C_LU,  21'h0,     2'd0};
    tbl[2]  = '{1, 0, 0, 0, 1, 0, 0, 0, 21'h0,     0, 0, C_RUN, 21'h0,     2'd0};
    tbl[3]  = '{1, 7, 5, 7, 1, 1, 0, 0, 21'h0,     0, 0, C_LU,  21'h0,     2'd0};
    tbl[4]  = '{1, 7, 5, 7, 1, 0, 0, 0, 21'h0,     0, 0, C_RUN, 21'h0,     2'd0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 1, 1, 21'h00400, 0, 0, C_BR,  21'h00400, 2'd0};
    tbl[6]  = '{1, 3, 3, 0, 1, 0, 1, 1, 21'h01234, 0, 0, C_BR,  21'h01234, 2'd0};
    tbl[7]  = '{1, 3, 3, 0, 1, 0, 1, 0, 21'h00777, 0, 0, C_LU,  21'h0,     2'd0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 21'h0,     1, 0, C_MEM, 21'h0,     2'd1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 21'h00055, 1, 0, C_MEM, 21'h0,     2'd1};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 21'h00055, 1, 1, C_BR,  21'h00055, 2'd0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 21'h0,     1, 1, C_RUN, 21'h0,     2'd0};

    idle_inputs();
    rst = 1;
    #1;
    do_reset();
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_stall", 32'(stall_cycles), 32'd0);

    // vector table
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      ex_mem_read = tbl[i].mr; ex_rd = tbl[i].rd; id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2;
      id_use_rs1 = tbl[i].u1; id_use_rs2 = tbl[i].u2; ex_branch = tbl[i].br;
      ex_taken = tbl[i].tk; ex_target = tbl[i].tgt; mem_req = tbl[i].mreq;
      mem_ready = tbl[i].mrdy;
      #2;
      chk($sformatf("tbl%0d_ctrl", i), 32'(dut_ctrl()), 32'(tbl[i].ectrl));
      chk($sformatf("tbl%0d_target", i), 32'(pc_target), 32'(tbl[i].etgt));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_state", i), 32'(state_o), 32'(tbl[i].est));
    end
    chk("tbl_stall_cycles", 32'(stall_cycles), 32'd5);
    chk("tbl_flush_events", 32'(flush_events), 32'd3);

    // three-cycle memory wait
    do_reset();
    idle_inputs();
    mem_req = 1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("memwait_wb_flush", 32'(mem_wb_flush), 32'd1);
      chk("memwait_pc_en", 32'(pc_en), 32'd0);
      @(posedge clk);
      #1;
      chk("memwait_state", 32'(state_o), 32'd1);
    end
    mem_ready = 1;
    #2;
    chk("memdone_pc_en", 32'(pc_en), 32'd1);
    @(posedge clk);
    #1;
    chk("memdone_state", 32'(state_o), 32'd0);
    chk("memdone_stall", 32'(stall_cycles), 32'd3);

    // timeout into FAULT, then reset out
    do_reset();
    idle_inputs();
    mem_req = 1;
    repeat (TMO) step();
    chk("timeout_state", 32'(state_o), 32'd3);
    chk("timeout_err_set", 32'(mem_timeout_err), 32'd1);
    #2;
    chk("fault_ctrl", 32'(dut_ctrl()), 32'(C_FROZE));
    #1;
    do_reset();
    chk("fault_rst_state", 32'(state_o), 32'd0);
    chk("fault_rst_err", 32'(mem_timeout_err), 32'd0);

    // halt beats memory stall and redirect, and holds
    idle_inputs();
    halt_wb = 1; mem_req = 1; ex_branch = 1; ex_taken = 1; ex_target = 21'h00123;
    step();
    chk("halt_state", 32'(state_o), 32'd2);
    idle_inputs();
    ex_mem_read = 1; ex_rd = 2; id_rs1 = 2; id_use_rs1 = 1;
    step();
    ex_branch = 1; ex_taken = 1;
    step();
    chk("halt_hold_state", 32'(state_o), 32'd2);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 59) == 0);
      id_rs1      = RW'($urandom_range(0, 3));
      id_rs2      = RW'($urandom_range(0, 3));
      ex_rd       = RW'($urandom_range(0, 3));
      id_use_rs1  = $urandom_range(0, 1) != 0;
      id_use_rs2  = $urandom_range(0, 1) != 0;
      ex_mem_read = $urandom_range(0, 1) != 0;
      ex_branch   = $urandom_range(0, 2) == 0;
      ex_taken    = $urandom_range(0, 1) != 0;
      ex_target   = PCW'($urandom);
      mem_req     = $urandom_range(0, 2) == 0;
      mem_ready   = $urandom_range(0, 2) != 0;
      halt_wb     = $urandom_range(0, 99) == 0;
      step();
    end
    rst = 0;

    // stall counter saturation
    do_reset();
    idle_inputs();
    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    repeat (65540) @(posedge clk);
    #3;
    chk("sat_stall", 32'(stall_cycles), 32'hFFFF);
    chk("sat_pc_en", 32'(pc_en), 32'd0);
    @(posedge clk);
    #3;
    chk("sat_stall_hold", 32'(stall_cycles), 32'hFFFF);
    #1;
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
